threewire_cmd_sequencer: RTL and testbench

THREEWIRE_CMD_SEQUENCER -- requirements
Module: threewire_cmd_sequencer

---
 rtl/threewire_pkg.sv | 28 ++
 rtl/threewire_cmd_fifo.sv | 63 ++++++
 rtl/threewire_cmd_sequencer.sv | 174 +++++++++++++++++
 tb/tb_threewire_cmd_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/threewire_pkg.sv
// threewire_pkg
// Shared definitions for the 3-wire command sequencer: FSM state encoding,
// the window in which the master must acknowledge a start pulse, and the
// width helpers used to size the command FIFO entry and the cycle counter.
package threewire_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_RESP      = 3'd4
   } tws_state_e;

   // Cycles after ISSUE within which in_tw_in_progress must rise.
   localparam int unsigned TWS_BUSY_WINDOW = 4;

   // One FIFO entry holds {wr, addr, wr_data}.
   function automatic int unsigned tws_entry_width(input int unsigned addr_bits,
                                                   input int unsigned data_bits);
      return 1 + addr_bits + data_bits;
   endfunction

   function automatic int unsigned tws_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/threewire_cmd_fifo.sv
// threewire_cmd_fifo
// First-word-fall-through FIFO: the head entry is visible on out_data
// whenever out_empty is low. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
// Ports:
//   in_clk, in_rst_n   clock, asynchronous active-low reset
//   in_push, in_data   write an entry (ignored when full)
//   in_pop             drop the head entry (ignored when empty)
//   out_data           current head entry
//   out_full/out_empty occupancy flags, registered-pointer based
module threewire_cmd_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic             in_push,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_pop,
   output logic [WIDTH-1:0] out_data,
   output logic             out_full,
   output logic             out_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic             do_push;
   logic             do_pop;

   assign out_empty = (wr_ptr_q == rd_ptr_q);
   assign out_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign out_data  = mem_q[rd_ptr_q[PTR_W-1:0]];

   assign do_push = in_push && !out_full;
   assign do_pop  = in_pop && !out_empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: an entry is only observed after it is written.
   always_ff @(posedge in_clk) begin
      if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= in_data;
   end

endmodule

// File: rtl/threewire_cmd_sequencer.sv
// threewire_cmd_sequencer
// Queues read/write commands and plays them one at a time into a 3-wire
// master, then returns one response per command in order.
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high; a producer holds its payload stable while valid is high and
// ready is low. Commands: in_cmd_valid/out_cmd_ready. Responses:
// out_rsp_valid/in_rsp_ready.
// Ports:
//   in_clk, in_rst_n                      clock, asynchronous active-low reset
//   in_cmd_*/out_cmd_ready                command input (wr, addr, wr_data)
//   out_rsp_*/in_rsp_ready                response output (wr, rd_data, err)
//   out_busy                              queued, active or unacknowledged work
//   out_tw_*                              start pulse and fields to the master
//   in_tw_rd_data, in_tw_in_progress      status from the master
module threewire_cmd_sequencer
   import threewire_pkg::*;
#(
   parameter int unsigned TWS_ADDRESS_BITS   = 10,
   parameter int unsigned TWS_DATA_BITS      = 32,
   parameter int unsigned TWS_FIFO_DEPTH     = 4,
   parameter int unsigned TWS_TIMEOUT_CYCLES = 4096
) (
   input  logic                        in_clk,
   input  logic                        in_rst_n,
   input  logic                        in_cmd_valid,
   output logic                        out_cmd_ready,
   input  logic                        in_cmd_wr,
   input  logic [TWS_ADDRESS_BITS-1:0] in_cmd_addr,
   input  logic [TWS_DATA_BITS-1:0]    in_cmd_wr_data,
   output logic                        out_rsp_valid,
   input  logic                        in_rsp_ready,
   output logic                        out_rsp_wr,
   output logic [TWS_DATA_BITS-1:0]    out_rsp_rd_data,
   output logic                        out_rsp_err,
   output logic                        out_busy,
   output logic                        out_tw_start,
   output logic                        out_tw_mode_wr,
   output logic [TWS_ADDRESS_BITS-1:0] out_tw_addr,
   output logic [TWS_DATA_BITS-1:0]    out_tw_wr_data,
   input  logic [TWS_DATA_BITS-1:0]    in_tw_rd_data,
   input  logic                        in_tw_in_progress
);

   localparam int unsigned ENTRY_W = tws_entry_width(TWS_ADDRESS_BITS, TWS_DATA_BITS);
   localparam int unsigned CNT_W   = tws_max($clog2(TWS_TIMEOUT_CYCLES),
                                             $clog2(TWS_BUSY_WINDOW));

   tws_state_e                  state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        ready_en_q;
   logic                        mode_wr_q, mode_wr_d;
   logic [TWS_ADDRESS_BITS-1:0] addr_q, addr_d;
   logic [TWS_DATA_BITS-1:0]    wr_data_q, wr_data_d;
   logic [TWS_DATA_BITS-1:0]    rsp_rd_data_q, rsp_rd_data_d;
   logic                        rsp_err_q, rsp_err_d;

   logic [ENTRY_W-1:0]          fifo_in;
   logic [ENTRY_W-1:0]          fifo_head;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic                        fifo_pop;
   logic                        timeout_hit;
   logic                        window_hit;

   // ready_en_q keeps out_cmd_ready low during reset and releases it on the
   // first clock after deassertion; it never looks at the pop.
   assign out_cmd_ready = ready_en_q && !fifo_full;
   assign fifo_in       = {in_cmd_wr, in_cmd_addr, in_cmd_wr_data};

   threewire_cmd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (TWS_FIFO_DEPTH)
   ) u_fifo (
      .in_clk    (in_clk),
      .in_rst_n  (in_rst_n),
      .in_push   (in_cmd_valid && out_cmd_ready),
      .in_data   (fifo_in),
      .in_pop    (fifo_pop),
      .out_data  (fifo_head),
      .out_full  (fifo_full),
      .out_empty (fifo_empty)
   );

   // cnt_q is 0 in ISSUE and counts cycles since then; reaching N-1 means the
   // N-th cycle after ISSUE is the one that enters RESP.
   assign timeout_hit = (cnt_q == CNT_W'(TWS_TIMEOUT_CYCLES - 1));
   assign window_hit  = (cnt_q == CNT_W'(TWS_BUSY_WINDOW - 1));

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mode_wr_d     = mode_wr_q;
      addr_d        = addr_q;
      wr_data_d     = wr_data_q;
      rsp_rd_data_d = rsp_rd_data_q;
      rsp_err_d     = rsp_err_q;
      fifo_pop      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && !in_tw_in_progress) begin
               fifo_pop  = 1'b1;
               mode_wr_d = fifo_head[ENTRY_W-1];
               addr_d    = fifo_head[TWS_DATA_BITS +: TWS_ADDRESS_BITS];
               wr_data_d = fifo_head[TWS_DATA_BITS-1:0];
               cnt_d     = '0;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (timeout_hit || (!in_tw_in_progress && window_hit)) begin
               rsp_err_d     = 1'b1;
               rsp_rd_data_d = '0;
               state_d       = ST_RESP;
            end else if (in_tw_in_progress) begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!in_tw_in_progress) begin
               rsp_err_d     = 1'b0;
               rsp_rd_data_d = mode_wr_q ? '0 : in_tw_rd_data;
               state_d       = ST_RESP;
            end else if (timeout_hit) begin
               rsp_err_d     = 1'b1;
               rsp_rd_data_d = '0;
               state_d       = ST_RESP;
            end
         end
         ST_RESP: begin
            if (in_rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         ready_en_q    <= 1'b0;
         mode_wr_q     <= 1'b0;
         addr_q        <= '0;
         wr_data_q     <= '0;
         rsp_rd_data_q <= '0;
         rsp_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ready_en_q    <= 1'b1;
         mode_wr_q     <= mode_wr_d;
         addr_q        <= addr_d;
         wr_data_q     <= wr_data_d;
         rsp_rd_data_q <= rsp_rd_data_d;
         rsp_err_q     <= rsp_err_d;
      end
   end

   assign out_tw_start    = (state_q == ST_ISSUE);
   assign out_tw_mode_wr  = mode_wr_q;
   assign out_tw_addr     = addr_q;
   assign out_tw_wr_data  = wr_data_q;
   assign out_rsp_valid   = (state_q == ST_RESP);
   assign out_rsp_wr      = mode_wr_q;
   assign out_rsp_rd_data = rsp_rd_data_q;
   assign out_rsp_err     = rsp_err_q;
   assign out_busy        = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_threewire_cmd_sequencer.sv
// Directed bench for threewire_cmd_sequencer. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_threewire_cmd_sequencer;

   localparam int A = 10;
   localparam int D = 32;
   localparam int RW = D + 2; // expected response: {wr, err, rd_data}

   logic         in_clk = 1'b0;
   logic         in_rst_n;
   logic         in_cmd_valid;
   logic         out_cmd_ready;
   logic         in_cmd_wr;
   logic [A-1:0] in_cmd_addr;
   logic [D-1:0] in_cmd_wr_data;
   logic         out_rsp_valid;
   logic         in_rsp_ready;
   logic         out_rsp_wr;
   logic [D-1:0] out_rsp_rd_data;
   logic         out_rsp_err;
   logic         out_busy;
   logic         out_tw_start;
   logic         out_tw_mode_wr;
   logic [A-1:0] out_tw_addr;
   logic [D-1:0] out_tw_wr_data;
   logic [D-1:0] in_tw_rd_data;
   logic         in_tw_in_progress;

   int checks   = 0;
   int failures = 0;
   logic [RW-1:0] exp_q[$];

   threewire_cmd_sequencer dut (
      .in_clk            (in_clk),
      .in_rst_n          (in_rst_n),
      .in_cmd_valid      (in_cmd_valid),
      .out_cmd_ready     (out_cmd_ready),
      .in_cmd_wr         (in_cmd_wr),
      .in_cmd_addr       (in_cmd_addr),
      .in_cmd_wr_data    (in_cmd_wr_data),
      .out_rsp_valid     (out_rsp_valid),
      .in_rsp_ready      (in_rsp_ready),
      .out_rsp_wr        (out_rsp_wr),
      .out_rsp_rd_data   (out_rsp_rd_data),
      .out_rsp_err       (out_rsp_err),
      .out_busy          (out_busy),
      .out_tw_start      (out_tw_start),
      .out_tw_mode_wr    (out_tw_mode_wr),
      .out_tw_addr       (out_tw_addr),
      .out_tw_wr_data    (out_tw_wr_data),
      .in_tw_rd_data     (in_tw_rd_data),
      .in_tw_in_progress (in_tw_in_progress)
   );

   // ---------------- clock / reset ----------------
   always #5 in_clk = ~in_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1);
   end

   // ---------------- scoreboard helper ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called on a falling edge; returns on the falling edge after acceptance.
   task automatic push(input logic wr, input logic [A-1:0] addr, input logic [D-1:0] data);
      int n = 0;
      while (out_cmd_ready !== 1'b1 && n < 200) begin
         @(negedge in_clk);
         n++;
      end
      chk("push_ready", {63'd0, out_cmd_ready}, 64'd1);
      in_cmd_valid   = 1'b1;
      in_cmd_wr      = wr;
      in_cmd_addr    = addr;
      in_cmd_wr_data = data;
      @(negedge in_clk);
      in_cmd_valid   = 1'b0;
   endtask

   task automatic wait_start(input string tag, output int n);
      n = 0;
      while (out_tw_start !== 1'b1 && n < 100) begin
         @(negedge in_clk);
         n++;
      end
      chk({tag, "_start_seen"}, {63'd0, out_tw_start}, 64'd1);
   endtask

   task automatic wait_rsp(input string tag, input int limit, output int n);
      n = 0;
      while (out_rsp_valid !== 1'b1 && n < limit) begin
         @(negedge in_clk);
         n++;
      end
      chk({tag, "_rsp_seen"}, {63'd0, out_rsp_valid}, 64'd1);
   endtask

   // Master model: busy for busy_len cycles, then done with rd_val.
   // Checks that no second start appears and the fields stay put meanwhile.
   task automatic serve(input int busy_len, input logic [D-1:0] rd_val);
      logic         m = out_tw_mode_wr;
      logic [A-1:0] a = out_tw_addr;
      logic [D-1:0] w = out_tw_wr_data;
      int bad = 0;
      in_tw_in_progress = 1'b1;
      repeat (busy_len) begin
         @(negedge in_clk);
         if (out_tw_start !== 1'b0 || out_tw_mode_wr !== m ||
             out_tw_addr !== a || out_tw_wr_data !== w) bad++;
      end
      in_tw_in_progress = 1'b0;
      in_tw_rd_data     = rd_val;
      chk("serve_stable", 64'(bad), 64'd0);
   endtask

   task automatic accept();
      in_rsp_ready = 1'b1;
      @(negedge in_clk);
      in_rsp_ready = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int bad;
      logic [RW-1:0] held;
      logic [D-1:0] vals [5];
      logic         wrs  [5];

      in_rst_n = 1'b0;
      in_cmd_valid = 1'b0; in_cmd_wr = 1'b0; in_cmd_addr = '0; in_cmd_wr_data = '0;
      in_rsp_ready = 1'b0; in_tw_rd_data = '0; in_tw_in_progress = 1'b0;
      repeat (3) @(negedge in_clk);

      // Reset state
      chk("rst_cmd_ready", {63'd0, out_cmd_ready}, 64'd0);
      chk("rst_rsp_valid", {63'd0, out_rsp_valid}, 64'd0);
      chk("rst_busy",      {63'd0, out_busy},      64'd0);
      chk("rst_start",     {63'd0, out_tw_start},  64'd0);
      chk("rst_addr",      64'(out_tw_addr),       64'd0);
      in_rst_n = 1'b1;
      @(negedge in_clk);
      chk("rst_release_ready", {63'd0, out_cmd_ready}, 64'd1);

      // Write 0x155 / 0xDEADBEEF, master busy 50 cycles
      push(1'b1, 10'h155, 32'hDEADBEEF);
      wait_start("t1", n);
      chk("t1_start_latency", 64'(n), 64'd1);
      chk("t1_mode", {63'd0, out_tw_mode_wr}, 64'd1);
      chk("t1_addr", 64'(out_tw_addr), 64'h155);
      chk("t1_wdata", 64'(out_tw_wr_data), 64'hDEADBEEF);
      serve(50, 32'hAAAA5555);
      wait_rsp("t1", 10, n);
      chk("t1_rsp_latency", 64'(n), 64'd1);
      chk("t1_rsp", {out_rsp_wr, out_rsp_err, out_rsp_rd_data}, {1'b1, 1'b0, 32'h0});
      accept();
      chk("t1_rsp_gone", {63'd0, out_rsp_valid}, 64'd0);
      chk("t1_idle_busy", {63'd0, out_busy}, 64'd0);

      // Read 0x3FF returning 0x12345678
      push(1'b0, 10'h3FF, 32'h0);
      wait_start("t2", n);
      chk("t2_mode", {63'd0, out_tw_mode_wr}, 64'd0);
      chk("t2_addr", 64'(out_tw_addr), 64'h3FF);
      serve(5, 32'h12345678);
      wait_rsp("t2", 10, n);
      chk("t2_rsp", {out_rsp_wr, out_rsp_err, out_rsp_rd_data}, {1'b0, 1'b0, 32'h12345678});
      accept();

      // Reset during WAIT_DONE with two commands queued
      push(1'b0, 10'h100, 32'h0);
      push(1'b1, 10'h101, 32'h01010101);
      push(1'b1, 10'h102, 32'h02020202);
      in_tw_in_progress = 1'b1;
      repeat (3) @(negedge in_clk);
      chk("t5_busy_before", {63'd0, out_busy}, 64'd1);
      chk("t5_addr_before", 64'(out_tw_addr), 64'h100);
      #2;
      in_rst_n = 1'b0;
      #1;
      chk("t5_rst_cmd_ready", {63'd0, out_cmd_ready}, 64'd0);
      chk("t5_rst_rsp_valid", {63'd0, out_rsp_valid}, 64'd0);
      chk("t5_rst_err",       {63'd0, out_rsp_err},   64'd0);
      chk("t5_rst_busy",      {63'd0, out_busy},      64'd0);
      chk("t5_rst_start",     {63'd0, out_tw_start},  64'd0);
      chk("t5_rst_mode",      {63'd0, out_tw_mode_wr}, 64'd0);
      chk("t5_rst_addr",      64'(out_tw_addr),       64'd0);
      chk("t5_rst_wdata",     64'(out_tw_wr_data),    64'd0);
      chk("t5_rst_rd_data",   64'(out_rsp_rd_data),   64'd0);
      in_tw_in_progress = 1'b0;
      repeat (2) @(negedge in_clk);
      in_rst_n = 1'b1;
      @(negedge in_clk);
      chk("t5_ready_after", {63'd0, out_cmd_ready}, 64'd1);
      chk("t5_busy_after",  {63'd0, out_busy},      64'd0);
      bad = 0;
      repeat (30) begin
         @(negedge in_clk);
         if (out_tw_start !== 1'b0 || out_rsp_valid !== 1'b0) bad++;
      end
      chk("t5_no_activity", 64'(bad), 64'd0);

      // Five commands with depth 4 and responses held off
      wrs[0] = 1'b1; wrs[1] = 1'b0; wrs[2] = 1'b1; wrs[3] = 1'b0; wrs[4] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vals[i] = 32'hA0000000 | 32'(i + 1);
         exp_q.push_back({wrs[i], 1'b0, (wrs[i] ? 32'h0 : vals[i])});
      end
      in_tw_in_progress = 1'b1;  // master busy: nothing leaves the FIFO
      for (int i = 0; i < 4; i++)
         push(wrs[i], 10'(i + 1), 32'h11111111 * 32'(i + 1));
      chk("t3_full_ready", {63'd0, out_cmd_ready}, 64'd0);
      chk("t3_no_start_blocked", {63'd0, out_tw_start}, 64'd0);
      in_tw_in_progress = 1'b0;
      @(negedge in_clk);
      chk("t3_start0", {63'd0, out_tw_start}, 64'd1);
      chk("t3_addr0", 64'(out_tw_addr), 64'h1);
      chk("t3_ready_after_pop", {63'd0, out_cmd_ready}, 64'd1);
      push(wrs[4], 10'd5, 32'h55555555);
      serve(3, vals[0]);
      wait_rsp("t3_0", 10, n);
      // Response held 20 cycles: fields stable, nothing new issued
      held = {out_rsp_wr, out_rsp_err, out_rsp_rd_data};
      bad = 0;
      repeat (20) begin
         @(negedge in_clk);
         if (out_rsp_valid !== 1'b1 || out_tw_start !== 1'b0 ||
             {out_rsp_wr, out_rsp_err, out_rsp_rd_data} !== held) bad++;
      end
      chk("t6_hold_stable", 64'(bad), 64'd0);
      chk("t6_fifo_full", {63'd0, out_cmd_ready}, 64'd0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            wait_start("t3_n", n);
            chk("t3_order_addr", 64'(out_tw_addr), 64'(i + 1));
            serve(3, vals[i]);
            wait_rsp("t3_n", 10, n);
         end
         chk("t3_rsp", 64'({out_rsp_wr, out_rsp_err, out_rsp_rd_data}), 64'(exp_q.pop_front()));
         accept();
      end
      chk("t3_drained", {63'd0, out_busy}, 64'd0);

      // Master never raises in_progress
      push(1'b0, 10'h0AA, 32'h0);
      wait_start("t4a", n);
      wait_rsp("t4a", 20, n);
      chk("t4a_latency", 64'(n), 64'd4);
      chk("t4a_rsp", {out_rsp_wr, out_rsp_err, out_rsp_rd_data}, {1'b0, 1'b1, 32'h0});
      accept();

      // Master stuck busy
      push(1'b0, 10'h2AA, 32'h0);
      wait_start("t4b", n);
      in_tw_in_progress = 1'b1;
      in_tw_rd_data     = 32'hFFFFFFFF;
      wait_rsp("t4b", 5000, n);
      chk("t4b_latency", 64'(n), 64'd4096);
      chk("t4b_rsp", {out_rsp_wr, out_rsp_err, out_rsp_rd_data}, {1'b0, 1'b1, 32'h0});
      accept();
      in_tw_in_progress = 1'b0;
      @(negedge in_clk);
      chk("t4b_idle", {63'd0, out_busy}, 64'd0);

      // ---------------- report ----------------
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
